// File: rtl/cpu_pkg.sv
// Shared opcode, state and strobe definitions for the RISC CPU controller.
package cpu_pkg;

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_S5,
    ST_S6,
    ST_S7,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic load_ir;
    logic rd;
    logic wr;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } ctrl_t;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) ||
           (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Maps the state being entered, opcode and skip flag to the strobe set
// that the output registers capture.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  state_e      state_i,
  input  logic [2:0]  opcode_i,
  input  logic        skip_i,
  output ctrl_t       ctrl_o
);

  logic alu, sto, skz;

  always_comb begin
    alu    = is_alu(opcode_i);
    sto    = (opcode_i == OP_STO);
    skz    = (opcode_i == OP_SKZ);
    ctrl_o = '0;
    unique case (state_i)
      ST_S0, ST_S1: begin
        ctrl_o.load_ir = 1'b1;
        ctrl_o.rd      = 1'b1;
        ctrl_o.inc_pc  = 1'b1;
      end
      ST_S3: ctrl_o.halt = (opcode_i == OP_HLT);
      ST_S4: begin
        ctrl_o.load_pc     = (opcode_i == OP_JMP);
        ctrl_o.rd          = alu;
        ctrl_o.datactl_ena = sto;
      end
      ST_S5: begin
        ctrl_o.rd          = alu;
        ctrl_o.load_acc    = alu;
        ctrl_o.wr          = sto;
        ctrl_o.datactl_ena = sto;
        ctrl_o.inc_pc      = skz && skip_i;
      end
      // Bus stays driven one cycle past wr for hold time.
      ST_S6: ctrl_o.datactl_ena = sto;
      ST_S7: ctrl_o.inc_pc = skz && skip_i;
      ST_HALTED: ctrl_o.halt = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: state register, skip flag and registered strobes
// for fetch, execute and halt of the simple RISC CPU.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt
);

  state_e state_q, state_d;
  logic   skip_q, skip_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ena ? ST_S0 : ST_IDLE;
      ST_S0:     state_d = ST_S1;
      ST_S1:     state_d = ST_S2;
      ST_S2:     state_d = ST_S3;
      ST_S3:     state_d = (opcode == OP_HLT) ? ST_HALTED : ST_S4;
      ST_S4:     state_d = ST_S5;
      ST_S5:     state_d = ST_S6;
      ST_S6:     state_d = ST_S7;
      ST_S7:     state_d = ena ? ST_S0 : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // zero is captured on the S4->S5 edge and feeds the S5 strobe directly.
  assign skip_d = (state_q == ST_S4) ? zero : skip_q;

  cpu_ctrl_decode u_decode (
    .state_i  (state_d),
    .opcode_i (opcode),
    .skip_i   (skip_d),
    .ctrl_o   (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      skip_q  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign load_ir     = ctrl_q.load_ir;
  assign rd          = ctrl_q.rd;
  assign wr          = ctrl_q.wr;
  assign inc_pc      = ctrl_q.inc_pc;
  assign load_pc     = ctrl_q.load_pc;
  assign load_acc    = ctrl_q.load_acc;
  assign datactl_ena = ctrl_q.datactl_ena;
  assign halt        = ctrl_q.halt;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: cycle-position reference model plus directed
// literal traces, followed by randomized ena/opcode/zero/reset traffic.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       zero = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(load_ir), .rd(rd), .wr(wr), .inc_pc(inc_pc),
    .load_pc(load_pc), .load_acc(load_acc),
    .datactl_ena(datactl_ena), .halt(halt)
  );

  always #5 clk = ~clk;

  logic [7:0] dv;
  assign dv = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [9:0] act,
                     input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Model: position 1..8 within the current instruction, 0 when idle.
  int         m_pos = 0;
  logic [2:0] m_opc = 3'b000;
  logic       m_skip = 1'b0;
  logic       m_halted = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0; m_opc <= 3'b000; m_skip <= 1'b0; m_halted <= 1'b0;
    end else if (m_halted) begin
      m_pos <= 0;
    end else if (m_pos == 0 || m_pos == 8) begin
      m_pos <= ena ? 1 : 0;
    end else if (m_pos == 4 && m_opc == OP_HLT) begin
      m_halted <= 1'b1;
      m_pos    <= 0;
    end else begin
      m_pos <= m_pos + 1;
      if (m_pos == 3) m_opc <= opcode;
      if (m_pos == 5) m_skip <= zero;
    end
  end

  function automatic logic [7:0] mexp(input int p, input logic [2:0] op,
                                      input logic sk, input logic h);
    logic alu, sto, skz, jmp, hlt, fetch;
    alu   = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) ||
            (op == OP_LDA);
    sto   = (op == OP_STO);
    skz   = (op == OP_SKZ);
    jmp   = (op == OP_JMP);
    hlt   = (op == OP_HLT);
    fetch = (p == 1) || (p == 2);
    if (h) return 8'h01;
    return {fetch,
            fetch || (alu && (p == 5 || p == 6)),
            sto && p == 6,
            fetch || (skz && sk && (p == 6 || p == 8)),
            jmp && p == 5,
            alu && p == 6,
            sto && p >= 5 && p <= 7,
            hlt && p == 4};
  endfunction

  always @(negedge clk)
    if (chk_en)
      chk("cycle_vs_model", {2'b00, dv},
          {2'b00, mexp(m_pos, m_opc, m_skip, m_halted)});

  logic [9:0] c_lir, c_rd, c_wr, c_inc, c_lpc, c_lacc, c_dct, c_hlt;

  // Start one instruction from IDLE; bit i of each trace is cycle i+1.
  task automatic cap(input logic [2:0] op, input logic zv,
                     input int drop_at, input bit tog);
    opcode = op; zero = zv; ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c_lir[i] = load_ir;  c_rd[i]   = rd;       c_wr[i]  = wr;
      c_inc[i] = inc_pc;   c_lpc[i]  = load_pc;  c_lacc[i] = load_acc;
      c_dct[i] = datactl_ena; c_hlt[i] = halt;
      if (i + 1 == drop_at) ena = 1'b0;
      if (tog && (i == 5 || i == 6)) zero = ~zero;
    end
  endtask

  task automatic settle();
    ena = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  int cnt;
  int hcnt;
  logic [2:0] op_r;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {2'b00, dv}, 10'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (dv != 8'h00) cnt++;
    end
    chk("idle_quiet", cnt[9:0], 10'd0);

    cap(OP_LDA, 1'b0, 0, 1'b0);
    chk("lda_load_ir", c_lir, 10'b11_0000_0011);
    chk("lda_rd", {2'b00, c_rd[7:0]}, 10'b00_0011_0011);
    chk("lda_load_acc", {2'b00, c_lacc[7:0]}, 10'b00_0010_0000);
    settle();

    cap(OP_STO, 1'b0, 0, 1'b0);
    chk("sto_datactl", {2'b00, c_dct[7:0]}, 10'b00_0111_0000);
    chk("sto_wr", {2'b00, c_wr[7:0]}, 10'b00_0010_0000);
    chk("sto_rd", {2'b00, c_rd[7:0]}, 10'b00_0000_0011);
    settle();

    cap(OP_SKZ, 1'b1, 0, 1'b0);
    chk("skz_z1_inc", {2'b00, c_inc[7:0]}, 10'b00_1010_0011);
    settle();
    cap(OP_SKZ, 1'b0, 0, 1'b0);
    chk("skz_z0_inc", {2'b00, c_inc[7:0]}, 10'b00_0000_0011);
    settle();
    cap(OP_SKZ, 1'b1, 0, 1'b1);
    chk("skz_z1_tog_inc", {2'b00, c_inc[7:0]}, 10'b00_1010_0011);
    settle();
    cap(OP_SKZ, 1'b0, 0, 1'b1);
    chk("skz_z0_tog_inc", {2'b00, c_inc[7:0]}, 10'b00_0000_0011);
    settle();

    cap(OP_JMP, 1'b0, 0, 1'b0);
    chk("jmp_load_pc", {2'b00, c_lpc[7:0]}, 10'b00_0001_0000);
    settle();

    cap(OP_ADD, 1'b0, 3, 1'b0);
    chk("add_drop_load_ir", c_lir, 10'b00_0000_0011);
    chk("add_drop_load_acc", {2'b00, c_lacc[7:0]}, 10'b00_0010_0000);
    settle();

    ena = 1'b1; opcode = OP_STO;
    repeat (6) @(negedge clk);
    chk("sto_s5_wr", {8'd0, wr, datactl_ena}, 10'b00_0000_0011);
    ena = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("sto_rst_drop", {8'd0, wr, datactl_ena}, 10'd0);
    #1 rst_n = 1'b1;

    cap(OP_HLT, 1'b0, 0, 1'b0);
    chk("hlt_halt", c_hlt, 10'b11_1111_1000);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      ena = 1'($urandom_range(0, 1));
      if (halt) cnt++;
    end
    chk("halt_held", cnt[9:0], 10'd20);
    #1 rst_n = 1'b0;
    #1 chk("halt_async_clear", {2'b00, dv}, 10'd0);
    #1 rst_n = 1'b1;
    ena = 1'b0;

    hcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ena  = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      if (m_pos == 0 || m_pos == 1 || m_pos == 2 || m_pos == 8) begin
        op_r = 3'($urandom_range(0, 7));
        if (op_r == OP_HLT && $urandom_range(0, 1) == 0) op_r = OP_SKZ;
        opcode = op_r;
      end
      if (m_halted) hcnt++;
      else hcnt = 0;
      if (hcnt > 5 || $urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #1 chk("rand_async_reset", {2'b00, dv}, 10'd0);
        #1 rst_n = 1'b1;
        hcnt = 0;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
